// File: rtl/ibex_hpm_event_ctrl.sv
// Performance-counter increment control: owns mcountinhibit and mhpmevent3..31.
// Latency: events to counter_inc_o take 1 cycle with IBEX_HPM_EVENT_PIPE_EN, else 0.
// No backpressure: strobes and CSR writes are accepted every cycle.
// Optional macro IBEX_HPM_EVENT_PIPE_EN adds the events_q pipeline register.
module ibex_hpm_event_ctrl #(
  parameter int unsigned NumEvents      = 16,
  parameter int unsigned MHPMCounterNum = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 setback_i,
  input  logic [NumEvents-1:0] events_i,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  output logic [31:0]          counter_inc_o
);

  localparam logic [11:0] CsrMcountinhibit = 12'h320;
  localparam logic [11:0] CsrMhpmeventLo   = 12'h323;
  localparam logic [11:0] CsrMhpmeventHi   = 12'h33F;

  // Array needs at least one entry even when no HPM counters exist.
  localparam int unsigned NumHpm = (MHPMCounterNum > 0) ? MHPMCounterNum : 1;

  // Writable inhibit bits: mcycle, minstret and the implemented HPM counters.
  localparam logic [31:0] InhibitMask =
      32'h0000_0005 | (((32'h1 << MHPMCounterNum) - 32'h1) << 3);

  logic [31:0]          inhibit_q;
  logic [NumEvents-1:0] mhpmevent_q [NumHpm];
  logic [NumEvents-1:0] events_q;

`ifdef IBEX_HPM_EVENT_PIPE_EN
  // Register the raw event strobes so the increment path starts from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      events_q <= '0;
    end else if (setback_i) begin
      events_q <= '0;
    end else begin
      events_q <= events_i;
    end
  end
`else
  assign events_q = events_i;
`endif

  // CSR state: setback wins over a write in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inhibit_q <= '0;
      for (int i = 0; i < NumHpm; i++) begin
        mhpmevent_q[i] <= '0;
      end
    end else if (setback_i) begin
      inhibit_q <= '0;
      for (int i = 0; i < NumHpm; i++) begin
        mhpmevent_q[i] <= '0;
      end
    end else if (csr_we_i) begin
      if (csr_addr_i == CsrMcountinhibit) begin
        inhibit_q <= csr_wdata_i & InhibitMask;
      end
      for (int i = 0; i < MHPMCounterNum; i++) begin
        if (csr_addr_i == CsrMhpmeventLo + 12'(i)) begin
          mhpmevent_q[i] <= csr_wdata_i[NumEvents-1:0];
        end
      end
    end
  end

  // Address decode and read mux; unimplemented selectors read as zero.
  always_comb begin
    csr_hit_o   = 1'b0;
    csr_rdata_o = '0;
    if (csr_addr_i == CsrMcountinhibit) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = inhibit_q;
    end else if (csr_addr_i >= CsrMhpmeventLo && csr_addr_i <= CsrMhpmeventHi) begin
      csr_hit_o = 1'b1;
      for (int i = 0; i < MHPMCounterNum; i++) begin
        if (csr_addr_i == CsrMhpmeventLo + 12'(i)) begin
          csr_rdata_o[NumEvents-1:0] = mhpmevent_q[i];
        end
      end
    end
  end

  // One increment per counter per cycle, however many selected events fire.
  always_comb begin
    counter_inc_o    = '0;
    counter_inc_o[0] = events_q[0] & ~inhibit_q[0];
    counter_inc_o[2] = events_q[1] & ~inhibit_q[2];
    for (int i = 0; i < MHPMCounterNum; i++) begin
      counter_inc_o[i+3] = (|(events_q & mhpmevent_q[i])) & ~inhibit_q[i+3];
    end
  end

endmodule

// File: tb/tb_ibex_hpm_event_ctrl.sv
// Directed bench for ibex_hpm_event_ctrl with default parameters.
// Expectations follow the build: event-to-increment latency is 1 with
// IBEX_HPM_EVENT_PIPE_EN defined, otherwise 0.
module tb_ibex_hpm_event_ctrl;

`ifdef IBEX_HPM_EVENT_PIPE_EN
  localparam bit Pipe = 1'b1;
`else
  localparam bit Pipe = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        setback_i;
  logic [15:0] events_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;
  logic [31:0] counter_inc_o;

  int n_checks = 0;
  int n_fail   = 0;

  ibex_hpm_event_ctrl #(
    .NumEvents      (16),
    .MHPMCounterNum (10)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .setback_i     (setback_i),
    .events_i      (events_i),
    .csr_we_i      (csr_we_i),
    .csr_addr_i    (csr_addr_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_hit_o     (csr_hit_o),
    .counter_inc_o (counter_inc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni      = 1'b0;
    setback_i   = 1'b0;
    events_i    = '0;
    csr_we_i    = 1'b0;
    csr_addr_i  = 12'h320;
    csr_wdata_i = '0;
    next();
    next();
    events_i = 16'h0003;
    mid();
    check("rst_inhibit", csr_rdata_o, 32'h0);

    // 1: reset release with cycle and instret events held
    next();
    rst_ni = 1'b1;
    mid();
    check("t1_first_cycle", counter_inc_o, Pipe ? 32'h0 : 32'h5);
    next();
    mid();
    check("t1_second_cycle", counter_inc_o, 32'h5);

    // 2: mhpmevent3 selects event 2, single pulse
    events_i    = '0;
    next();
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h323;
    csr_wdata_i = 32'h4;
    mid();
    check("t2_read_in_write_cycle", csr_rdata_o, 32'h0);
    next();
    csr_we_i = 1'b0;
    events_i = 16'h0004;
    mid();
    check("t2_read_ev3", csr_rdata_o, 32'h4);
    check("t2_hit_ev3", {31'h0, csr_hit_o}, 32'h1);
    check("t2_inc_n", counter_inc_o, Pipe ? 32'h0 : 32'h8);
    next();
    events_i = '0;
    mid();
    check("t2_inc_n1", counter_inc_o, Pipe ? 32'h8 : 32'h0);
    next();
    mid();
    check("t2_inc_n2", counter_inc_o, 32'h0);

    // 3: inhibit everything
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h320;
    csr_wdata_i = 32'hFFFF_FFFF;
    events_i    = 16'hFFFF;
    next();
    csr_we_i = 1'b0;
    mid();
    check("t3_read_inhibit", csr_rdata_o, 32'h0000_1FFD);
    check("t3_inc_inhibited", counter_inc_o, 32'h0);
    next();
    mid();
    check("t3_inc_hold", counter_inc_o, 32'h0);
    csr_we_i    = 1'b1;
    csr_wdata_i = 32'h0;
    next();

    // 4: unimplemented selectors and address boundaries
    csr_addr_i  = 12'h334;
    csr_wdata_i = 32'h0000_FFFF;
    next();
    csr_we_i = 1'b0;
    mid();
    check("t4_read_ev20", csr_rdata_o, 32'h0);
    check("t4_hit_ev20", {31'h0, csr_hit_o}, 32'h1);
    check("t4_inc", counter_inc_o, 32'h0000_000D);
    csr_addr_i = 12'h321;
    #1;
    check("t4_hit_321", {31'h0, csr_hit_o}, 32'h0);
    check("t4_read_321", csr_rdata_o, 32'h0);
    csr_addr_i = 12'h322;
    #1;
    check("t4_hit_322", {31'h0, csr_hit_o}, 32'h0);
    csr_addr_i = 12'h31F;
    #1;
    check("t4_hit_31f", {31'h0, csr_hit_o}, 32'h0);
    csr_addr_i = 12'h340;
    #1;
    check("t4_hit_340", {31'h0, csr_hit_o}, 32'h0);
    csr_addr_i = 12'h33F;
    #1;
    check("t4_hit_33f", {31'h0, csr_hit_o}, 32'h1);
    check("t4_read_33f", csr_rdata_o, 32'h0);
    next();
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h32C;
    csr_wdata_i = 32'hFFFF_FFFF;
    next();
    csr_we_i = 1'b0;
    mid();
    check("t4_read_ev12", csr_rdata_o, 32'h0000_FFFF);
    check("t4_inc_ev12", counter_inc_o, 32'h0000_100D);
    next();
    csr_we_i   = 1'b1;
    csr_addr_i = 12'h32D;
    next();
    csr_we_i = 1'b0;
    mid();
    check("t4_read_ev13", csr_rdata_o, 32'h0);
    next();
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h320;
    csr_wdata_i = 32'h2;
    next();
    csr_we_i = 1'b0;
    mid();
    check("t4_inhibit_time_bit", csr_rdata_o, 32'h0);
    check("t4_inc_after_time_bit", counter_inc_o, 32'h0000_100D);

    // 5: setback beats a simultaneous write
    next();
    setback_i   = 1'b1;
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h320;
    csr_wdata_i = 32'h5;
    next();
    setback_i = 1'b0;
    csr_we_i  = 1'b0;
    mid();
    check("t5_read_inhibit", csr_rdata_o, 32'h0);
    check("t5_inc_next", counter_inc_o, Pipe ? 32'h0 : 32'h5);
    csr_addr_i = 12'h323;
    #1;
    check("t5_read_ev3", csr_rdata_o, 32'h0);
    csr_addr_i = 12'h32C;
    #1;
    check("t5_read_ev12", csr_rdata_o, 32'h0);
    next();
    mid();
    check("t5_inc_after", counter_inc_o, 32'h5);

    // 6: two selected events together give one increment
    events_i    = '0;
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h324;
    csr_wdata_i = 32'h0000_000C;
    next();
    csr_we_i = 1'b0;
    events_i = 16'h000C;
    mid();
    check("t6_inc_n", counter_inc_o, Pipe ? 32'h0 : 32'h10);
    next();
    events_i = '0;
    mid();
    check("t6_inc_n1", counter_inc_o, Pipe ? 32'h10 : 32'h0);
    next();
    mid();
    check("t6_inc_n2", counter_inc_o, 32'h0);

    // 7: asynchronous reset mid-operation
    csr_we_i    = 1'b1;
    csr_addr_i  = 12'h320;
    csr_wdata_i = 32'h5;
    events_i    = 16'h0003;
    next();
    csr_we_i = 1'b0;
    mid();
    check("t7_inc_inhibited", counter_inc_o, 32'h0);
    #1;
    rst_ni = 1'b0;
    #1;
    check("t7_async_inhibit", csr_rdata_o, 32'h0);
    check("t7_async_inc", counter_inc_o, Pipe ? 32'h0 : 32'h5);
    csr_addr_i = 12'h324;
    #1;
    check("t7_async_ev4", csr_rdata_o, 32'h0);
    next();
    rst_ni = 1'b1;
    next();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
